// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I$/D$ memory-side arbiter.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } arb_src_t;

    localparam int unsigned ARB_DPRI = 0;
    localparam int unsigned ARB_RR   = 1;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Generic memory bus: requester drives addr/wdata/ren/wen/byte_en, responder returns busy/rdata.
interface generic_bus_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ren;
    logic              wen;
    logic [BE_W-1:0]   byte_en;
    logic              busy;

    // Responder view: the arbiter as seen by a cache.
    modport generic_bus (
        input  addr, wdata, ren, wen, byte_en,
        output rdata, busy
    );

    // Requester view: the arbiter as master toward memory.
    modport cpu (
        output addr, wdata, ren, wen, byte_en,
        input  rdata, busy
    );

endinterface

// File: rtl/cache_mem_arbiter_arb_pick2.sv
// Combinational two-way request picker: D$ fixed priority or round-robin on contention.
module arb_pick2
    import cache_mem_arbiter_pkg::*;
(
    input  logic     i_req_i,
    input  logic     i_req_d,
    input  arb_src_t i_last_grant,
    input  logic     i_policy,
    output logic     o_grant_valid_c,
    output arb_src_t o_grant_src_c
);

    always_comb begin
        o_grant_valid_c = i_req_i | i_req_d;
        o_grant_src_c   = ICACHE;
        if (i_req_i && i_req_d) begin
            if (i_policy == 1'(ARB_RR)) begin
                o_grant_src_c = (i_last_grant == ICACHE) ? DCACHE : ICACHE;
            end else begin
                o_grant_src_c = DCACHE;
            end
        end else if (i_req_d) begin
            o_grant_src_c = DCACHE;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Merges I$ and D$ memory buses onto one memory bus; one transaction at a time,
// grant held until memory completes or the requester aborts.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned ARB_POLICY = ARB_DPRI,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    generic_bus_if.generic_bus         icache_bus_if,
    generic_bus_if.generic_bus         dcache_bus_if,
    generic_bus_if.cpu                 mem_bus_if,
    output logic                       arb_idle
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_t r_state;
    arb_state_t w_next_state;
    arb_src_t   r_last_grant;

    logic              w_req_i;
    logic              w_req_d;
    logic              w_grant_valid;
    arb_src_t          w_grant_src;

    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_ren;
    logic              w_mem_wen;
    logic [BE_W-1:0]   w_mem_byte_en;
    logic              w_i_busy;
    logic              w_d_busy;
    logic [DATA_W-1:0] w_i_rdata;
    logic [DATA_W-1:0] w_d_rdata;

    assign w_req_i = icache_bus_if.ren | icache_bus_if.wen;
    assign w_req_d = dcache_bus_if.ren | dcache_bus_if.wen;

    arb_pick2 u_pick (
        .i_req_i         (w_req_i),
        .i_req_d         (w_req_d),
        .i_last_grant    (r_last_grant),
        .i_policy        (1'(ARB_POLICY)),
        .o_grant_valid_c (w_grant_valid),
        .o_grant_src_c   (w_grant_src)
    );

    // State and last-grant registers; last_grant captured on entry to a grant state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_last_grant <= ICACHE;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_grant_valid) begin
                r_last_grant <= w_grant_src;
            end
        end
    end

    // Next state and bus steering; an abort suppresses the granted busy so no false completion is seen.
    always_comb begin
        w_next_state  = r_state;
        w_mem_addr    = '0;
        w_mem_wdata   = '0;
        w_mem_ren     = 1'b0;
        w_mem_wen     = 1'b0;
        w_mem_byte_en = '0;
        w_i_busy      = 1'b1;
        w_d_busy      = 1'b1;
        w_i_rdata     = '0;
        w_d_rdata     = '0;

        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = (w_grant_src == DCACHE) ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I: begin
                w_mem_addr    = icache_bus_if.addr;
                w_mem_wdata   = icache_bus_if.wdata;
                w_mem_ren     = icache_bus_if.ren;
                w_mem_wen     = icache_bus_if.wen;
                w_mem_byte_en = icache_bus_if.byte_en;
                w_i_rdata     = mem_bus_if.rdata;
                if (!w_req_i) begin
                    w_next_state = IDLE;
                end else begin
                    w_i_busy = mem_bus_if.busy;
                    if (!mem_bus_if.busy) begin
                        w_next_state = IDLE;
                    end
                end
            end
            GRANT_D: begin
                w_mem_addr    = dcache_bus_if.addr;
                w_mem_wdata   = dcache_bus_if.wdata;
                w_mem_ren     = dcache_bus_if.ren;
                w_mem_wen     = dcache_bus_if.wen;
                w_mem_byte_en = dcache_bus_if.byte_en;
                w_d_rdata     = mem_bus_if.rdata;
                if (!w_req_d) begin
                    w_next_state = IDLE;
                end else begin
                    w_d_busy = mem_bus_if.busy;
                    if (!mem_bus_if.busy) begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign mem_bus_if.addr     = w_mem_addr;
    assign mem_bus_if.wdata    = w_mem_wdata;
    assign mem_bus_if.ren      = w_mem_ren;
    assign mem_bus_if.wen      = w_mem_wen;
    assign mem_bus_if.byte_en  = w_mem_byte_en;
    assign icache_bus_if.busy  = w_i_busy;
    assign icache_bus_if.rdata = w_i_rdata;
    assign dcache_bus_if.busy  = w_d_busy;
    assign dcache_bus_if.rdata = w_d_rdata;

    assign arb_idle = (r_state == IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: one instance per arbitration policy.
module tb_cache_mem_arbiter;

    logic CLK;
    logic nRST;
    logic idle0;
    logic idle1;
    int   n_checks;
    int   n_fail;

    generic_bus_if #(.ADDR_W(32), .DATA_W(32)) ic0 ();
    generic_bus_if #(.ADDR_W(32), .DATA_W(32)) dc0 ();
    generic_bus_if #(.ADDR_W(32), .DATA_W(32)) mem0 ();
    generic_bus_if #(.ADDR_W(32), .DATA_W(32)) ic1 ();
    generic_bus_if #(.ADDR_W(32), .DATA_W(32)) dc1 ();
    generic_bus_if #(.ADDR_W(32), .DATA_W(32)) mem1 ();

    cache_mem_arbiter #(.ARB_POLICY(0), .ADDR_W(32), .DATA_W(32)) dut0 (
        .CLK           (CLK),
        .nRST          (nRST),
        .icache_bus_if (ic0),
        .dcache_bus_if (dc0),
        .mem_bus_if    (mem0),
        .arb_idle      (idle0)
    );

    cache_mem_arbiter #(.ARB_POLICY(1), .ADDR_W(32), .DATA_W(32)) dut1 (
        .CLK           (CLK),
        .nRST          (nRST),
        .icache_bus_if (ic1),
        .dcache_bus_if (dc1),
        .mem_bus_if    (mem1),
        .arb_idle      (idle1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (idle0 !== 1'b1) begin n_fail++; $display("FAIL reset_idle0: got %b exp 1", idle0); end
        n_checks++; if (idle1 !== 1'b1) begin n_fail++; $display("FAIL reset_idle1: got %b exp 1", idle1); end
        n_checks++; if ({ic0.busy, dc0.busy} !== 2'b11) begin n_fail++; $display("FAIL reset_busy0: got %b exp 11", {ic0.busy, dc0.busy}); end
        n_checks++; if ({ic1.busy, dc1.busy} !== 2'b11) begin n_fail++; $display("FAIL reset_busy1: got %b exp 11", {ic1.busy, dc1.busy}); end
        n_checks++; if ({mem0.ren, mem0.wen, mem1.ren, mem1.wen} !== 4'b0000) begin n_fail++; $display("FAIL reset_mem_rw: got %b exp 0000", {mem0.ren, mem0.wen, mem1.ren, mem1.wen}); end
        n_checks++; if (mem0.addr !== 32'h0 || mem0.wdata !== 32'h0 || mem0.byte_en !== 4'h0) begin n_fail++; $display("FAIL reset_mem_bus: got addr %h wdata %h be %h exp 0", mem0.addr, mem0.wdata, mem0.byte_en); end
        n_checks++; if (ic0.rdata !== 32'h0 || dc0.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h exp 0", ic0.rdata, dc0.rdata); end
    endtask

    task automatic test_d_read();
        dc0.ren = 1'b1; dc0.addr = 32'h100; mem0.busy = 1'b1;
        #1;
        n_checks++; if (mem0.ren !== 1'b0) begin n_fail++; $display("FAIL rd_c0_mem_ren: got %b exp 0", mem0.ren); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_checks++; if (mem0.ren !== 1'b1 || mem0.addr !== 32'h100) begin n_fail++; $display("FAIL rd_c%0d_mem: got ren %b addr %h exp 1 100", c, mem0.ren, mem0.addr); end
            n_checks++; if ({ic0.busy, dc0.busy} !== 2'b11) begin n_fail++; $display("FAIL rd_c%0d_busy: got %b exp 11", c, {ic0.busy, dc0.busy}); end
        end
        tick();
        mem0.busy = 1'b0; mem0.rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (dc0.busy !== 1'b0 || dc0.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_c4_d: got busy %b rdata %h exp 0 deadbeef", dc0.busy, dc0.rdata); end
        n_checks++; if (ic0.busy !== 1'b1 || ic0.rdata !== 32'h0) begin n_fail++; $display("FAIL rd_c4_i: got busy %b rdata %h exp 1 0", ic0.busy, ic0.rdata); end
        tick();
        dc0.ren = 1'b0; mem0.busy = 1'b1; mem0.rdata = 32'h0;
        #1;
        n_checks++; if (idle0 !== 1'b1 || dc0.busy !== 1'b1) begin n_fail++; $display("FAIL rd_c5_idle: got idle %b busy %b exp 1 1", idle0, dc0.busy); end
        tick();
    endtask

    task automatic test_reset_mid_grant();
        dc0.ren = 1'b1; dc0.addr = 32'h80; mem0.busy = 1'b1;
        tick();
        n_checks++; if (mem0.ren !== 1'b1 || idle0 !== 1'b0) begin n_fail++; $display("FAIL rst_pre_grant: got ren %b idle %b exp 1 0", mem0.ren, idle0); end
        nRST = 1'b0;
        #1;
        n_checks++; if ({mem0.ren, mem0.wen} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_mem_rw: got %b exp 00", {mem0.ren, mem0.wen}); end
        n_checks++; if ({ic0.busy, dc0.busy} !== 2'b11 || idle0 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_state: got busy %b idle %b exp 11 1", {ic0.busy, dc0.busy}, idle0); end
        dc0.ren = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        n_checks++; if (idle0 !== 1'b1 || mem0.ren !== 1'b0) begin n_fail++; $display("FAIL rst_post: got idle %b ren %b exp 1 0", idle0, mem0.ren); end
    endtask

    task automatic test_dpri_starve();
        ic0.ren = 1'b1; ic0.addr = 32'h10;
        dc0.ren = 1'b1; dc0.addr = 32'h20;
        mem0.busy = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            n_checks++; if (idle0 !== 1'b0 || mem0.addr !== 32'h20) begin n_fail++; $display("FAIL dpri_r%0d_grant: got idle %b addr %h exp 0 20", r, idle0, mem0.addr); end
            n_checks++; if (ic0.busy !== 1'b1 || dc0.busy !== 1'b0) begin n_fail++; $display("FAIL dpri_r%0d_busy: got i %b d %b exp 1 0", r, ic0.busy, dc0.busy); end
            tick();
            n_checks++; if (idle0 !== 1'b1) begin n_fail++; $display("FAIL dpri_r%0d_idle: got %b exp 1", r, idle0); end
        end
        ic0.ren = 1'b0; dc0.ren = 1'b0; mem0.busy = 1'b1;
        tick();
    endtask

    task automatic test_rr_alternate();
        logic exp_d [4];
        logic [31:0] exp_addr;
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
        ic1.ren = 1'b1; ic1.addr = 32'h10;
        dc1.ren = 1'b1; dc1.addr = 32'h20;
        for (int g = 0; g < 4; g++) begin
            exp_addr = exp_d[g] ? 32'h20 : 32'h10;
            tick();
            mem1.busy = 1'b1;
            #1;
            n_checks++; if (idle1 !== 1'b0 || mem1.addr !== exp_addr) begin n_fail++; $display("FAIL rr_g%0d_order: got idle %b addr %h exp 0 %h", g, idle1, mem1.addr, exp_addr); end
            n_checks++; if ({ic1.busy, dc1.busy} !== 2'b11) begin n_fail++; $display("FAIL rr_g%0d_busy_a: got %b exp 11", g, {ic1.busy, dc1.busy}); end
            tick();
            mem1.busy = 1'b0;
            #1;
            n_checks++; if ({ic1.busy, dc1.busy} !== (exp_d[g] ? 2'b10 : 2'b01) || idle1 !== 1'b0) begin n_fail++; $display("FAIL rr_g%0d_done: got busy %b idle %b exp %b 0", g, {ic1.busy, dc1.busy}, idle1, exp_d[g] ? 2'b10 : 2'b01); end
            tick();
            n_checks++; if (idle1 !== 1'b1 || mem1.ren !== 1'b0) begin n_fail++; $display("FAIL rr_g%0d_gap: got idle %b ren %b exp 1 0", g, idle1, mem1.ren); end
        end
        ic1.ren = 1'b0; dc1.ren = 1'b0; mem1.busy = 1'b1;
        tick();
    endtask

    task automatic test_d_write();
        ic0.wen = 1'b1; ic0.addr = 32'h300; ic0.wdata = 32'hCAFEF00D; ic0.byte_en = 4'b1111;
        dc0.wen = 1'b1; dc0.addr = 32'h200; dc0.wdata = 32'h12345678; dc0.byte_en = 4'b0011;
        mem0.busy = 1'b1;
        #1;
        n_checks++; if (mem0.wdata !== 32'h0 || mem0.wen !== 1'b0) begin n_fail++; $display("FAIL wr_idle_bus: got wdata %h wen %b exp 0 0", mem0.wdata, mem0.wen); end
        tick();
        n_checks++; if (mem0.addr !== 32'h200 || mem0.wdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_addr_data: got %h %h exp 200 12345678", mem0.addr, mem0.wdata); end
        n_checks++; if ({mem0.ren, mem0.wen} !== 2'b01 || mem0.byte_en !== 4'b0011) begin n_fail++; $display("FAIL wr_ctrl: got rw %b be %b exp 01 0011", {mem0.ren, mem0.wen}, mem0.byte_en); end
        tick();
        mem0.busy = 1'b0; ic0.wen = 1'b0;
        #1;
        n_checks++; if (mem0.wdata !== 32'h12345678 || dc0.busy !== 1'b0 || ic0.busy !== 1'b1) begin n_fail++; $display("FAIL wr_done: got wdata %h dbusy %b ibusy %b exp 12345678 0 1", mem0.wdata, dc0.busy, ic0.busy); end
        tick();
        dc0.wen = 1'b0; mem0.busy = 1'b1;
        #1;
        n_checks++; if (idle0 !== 1'b1 || mem0.wdata !== 32'h0) begin n_fail++; $display("FAIL wr_after: got idle %b wdata %h exp 1 0", idle0, mem0.wdata); end
        tick();
    endtask

    task automatic test_i_abort();
        ic0.ren = 1'b1; ic0.addr = 32'h40; mem0.busy = 1'b1;
        tick();
        n_checks++; if (mem0.ren !== 1'b1 || mem0.addr !== 32'h40 || ic0.busy !== 1'b1) begin n_fail++; $display("FAIL abort_grant: got ren %b addr %h busy %b exp 1 40 1", mem0.ren, mem0.addr, ic0.busy); end
        ic0.ren = 1'b0;
        #1;
        n_checks++; if (ic0.busy !== 1'b1 || mem0.ren !== 1'b0) begin n_fail++; $display("FAIL abort_drop: got busy %b ren %b exp 1 0", ic0.busy, mem0.ren); end
        tick();
        n_checks++; if (idle0 !== 1'b1 || ic0.busy !== 1'b1 || mem0.ren !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got idle %b busy %b ren %b exp 1 1 0", idle0, ic0.busy, mem0.ren); end
        tick();
        n_checks++; if (idle0 !== 1'b1) begin n_fail++; $display("FAIL abort_stay_idle: got %b exp 1", idle0); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nRST     = 1'b0;
        ic0.addr = '0; ic0.wdata = '0; ic0.ren = 1'b0; ic0.wen = 1'b0; ic0.byte_en = '0;
        dc0.addr = '0; dc0.wdata = '0; dc0.ren = 1'b0; dc0.wen = 1'b0; dc0.byte_en = '0;
        ic1.addr = '0; ic1.wdata = '0; ic1.ren = 1'b0; ic1.wen = 1'b0; ic1.byte_en = '0;
        dc1.addr = '0; dc1.wdata = '0; dc1.ren = 1'b0; dc1.wen = 1'b0; dc1.byte_en = '0;
        mem0.busy = 1'b1; mem0.rdata = '0;
        mem1.busy = 1'b1; mem1.rdata = '0;
        #2;
        test_reset();
        tick();
        nRST = 1'b1;
        tick();
        test_d_read();
        test_reset_mid_grant();
        test_dpri_starve();
        test_rr_alternate();
        test_d_write();
        test_i_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
